farrow_beam_sum: RTL

- Downstream stage of the Farrow fractional-delay block.
- Consumes its N_DN parallel beam outputs. Each beam is N_chanals time-multiplexed channel samples per frame, framed by vld/last.
- Sums all channels of a frame per beam, rounds, shifts and saturates the sum, then queues one parallel word per frame in an output FIFO with ready/valid handshake.
- Checks frame length and reports sticky error flags.

---
 rtl/farrow_beam_sum.sv | 126 ++++++++++++
 1 files changed

// File: rtl/farrow_beam_sum.sv
// farrow_beam_sum: per-beam channel-sum with round/shift/saturate into a FWFT output FIFO
// Frame framing errors, FIFO drops and saturation are reported as sticky flags.
module farrow_beam_sum #(
  parameter int N_chanals      = 8,
  parameter int N_DN           = 4,
  parameter int width_data_in  = 16,
  parameter int width_data_out = 16,
  parameter int shift_out      = 1,
  parameter int fifo_depth     = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     vld_in,
  input  logic                                     last_in,
  input  logic [N_DN-1:0][width_data_in-1:0]       data_in,
  output logic [N_DN-1:0][width_data_out-1:0]      data_out,
  output logic                                     vld_out,
  input  logic                                     rdy_out,
  input  logic                                     clr_err,
  output logic                                     err_frame,
  output logic                                     err_ovf,
  output logic                                     err_sat
);
  localparam int AW = width_data_in + $clog2(N_chanals);
  localparam int CW = $clog2(N_chanals);
  localparam int PW = $clog2(fifo_depth);
  localparam int SW = ((AW + 1 > width_data_out) ? AW + 1 : width_data_out) + 1;
  localparam logic [CW-1:0] LAST = CW'(N_chanals - 1);
  localparam logic [AW:0] RND = (shift_out == 0) ? '0 : (AW+1)'(1) << ((shift_out == 0) ? 0 : shift_out - 1);
  localparam logic signed [SW-1:0] HI = {{(SW-width_data_out+1){1'b0}}, {(width_data_out-1){1'b1}}};
  localparam logic signed [SW-1:0] LO = ~HI;
  typedef enum logic {ACC, RESYNC} state_t;
  state_t                              st_q;
  logic [CW-1:0]                       cnt_q;
  logic [N_DN-1:0][AW-1:0]             acc_q, s1_q;
  logic                                done_q, s1_vld_q;
  logic                                frame_evt, ovf_evt, sat_evt;
  logic signed [AW:0]                  sum [N_DN];
  logic signed [AW:0]                  shd [N_DN];
  logic signed [SW-1:0]                sh  [N_DN];
  logic [N_DN-1:0]                     clip;
  logic [N_DN-1:0][width_data_out-1:0] res;
  logic [N_DN-1:0][width_data_out-1:0] mem_q [fifo_depth];
  logic [PW:0]                         wr_q, rd_q;
  logic                                full, empty, push, pop;
  logic                                err_frame_q, err_ovf_q, err_sat_q;
  logic                                err_frame_d, err_ovf_d, err_sat_d;
  assign frame_evt = vld_in && st_q == ACC && (last_in != (cnt_q == LAST));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= ACC;
      cnt_q  <= '0;
      acc_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (vld_in && st_q == RESYNC) begin
        if (last_in) st_q <= ACC;
      end else if (vld_in) begin
        for (int l = 0; l < N_DN; l++)
          acc_q[l] <= (cnt_q == '0 ? AW'(0) : acc_q[l]) + AW'($signed(data_in[l]));
        cnt_q  <= (last_in || cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        done_q <= last_in && cnt_q == LAST;
        if (!last_in && cnt_q == LAST) st_q <= RESYNC;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q <= 1'b0;
      s1_q     <= '0;
    end else begin
      s1_vld_q <= done_q;
      if (done_q) s1_q <= acc_q;
    end
  end
  // Extra headroom bit keeps the rounding add from wrapping before the clamp.
  always_comb begin
    for (int l = 0; l < N_DN; l++) begin
      sum[l]  = $signed({s1_q[l][AW-1], s1_q[l]}) + $signed(RND);
      shd[l]  = sum[l] >>> shift_out;
      sh[l]   = {{(SW-AW-1){shd[l][AW]}}, shd[l]};
      clip[l] = (sh[l] > HI) || (sh[l] < LO);
      res[l]  = sh[l] > HI ? HI[width_data_out-1:0] : sh[l] < LO ? LO[width_data_out-1:0] : sh[l][width_data_out-1:0];
    end
  end
  assign full    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign empty   = wr_q == rd_q;
  assign pop     = !empty && rdy_out;
  assign push    = s1_vld_q && (!full || pop);
  assign ovf_evt = s1_vld_q && full && !pop;
  assign sat_evt = s1_vld_q && |clip;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + (PW+1)'(push);
      rd_q <= rd_q + (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[PW-1:0]] <= res;
  end
  assign vld_out  = !empty;
  assign data_out = empty ? '0 : mem_q[rd_q[PW-1:0]];
  always_comb begin
    err_frame_d = frame_evt || (err_frame_q && !clr_err);
    err_ovf_d   = ovf_evt   || (err_ovf_q   && !clr_err);
    err_sat_d   = sat_evt   || (err_sat_q   && !clr_err);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_frame_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_sat_q   <= 1'b0;
    end else begin
      err_frame_q <= err_frame_d;
      err_ovf_q   <= err_ovf_d;
      err_sat_q   <= err_sat_d;
    end
  end
  assign err_frame = err_frame_q;
  assign err_ovf   = err_ovf_q;
  assign err_sat   = err_sat_q;
endmodule
